// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient scheduler.
// Holds the controller state encoding and the coefficient type.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SWAP,
    FLUSH
  } state_t;

  localparam int COEF_W      = 16;
  localparam int TAP_LEN_DEF = 8;
  localparam int FLUSH_INIT  = TAP_LEN_DEF - 1;

  typedef logic signed [COEF_W-1:0] coef_t;

  function automatic int flush_init(input int taps);
    return taps - 1;
  endfunction

endpackage

// File: rtl/fir_cke_div.sv
// Sample-rate divider: one registered cke pulse every div+1 cycles.
// The >= compare means lowering div fires at once, never a long wrap.
module fir_cke_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] div,
  output logic         cke
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      cke <= 1'b0;
    end else if (cnt >= div) begin
      cnt <= '0;
      cke <= 1'b1;
    end else begin
      cnt <= cnt + W'(1);
      cke <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_coef_sched.sv
// FIR coefficient loader, atomic bank swap and post-swap flush control.
// Define FIR_COEF_RDBK_EN to add the registered active-bank readback port.
module fir_coef_sched
  import fir_ctrl_pkg::*;
#(
  parameter int TAP_LEN = 8,
  parameter int WIDTH   = 16,
  parameter int DIV_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIV_W-1:0]           div,
  input  logic                       cw_valid,
  output logic                       cw_ready,
  input  logic signed [WIDTH-1:0]    cw_data,
  input  logic                       cw_last,
  input  logic                       commit,
  output logic                       busy,
  output logic                       cke,
  output logic                       fir_clr,
  output logic [TAP_LEN*WIDTH-1:0]   tap,
  output logic                       dout_valid,
`ifdef FIR_COEF_RDBK_EN
  output logic                       load_err,
  input  logic [$clog2(TAP_LEN)-1:0] rd_addr,
  output logic [WIDTH-1:0]           rd_data
`else
  output logic                       load_err
`endif
);

  localparam int IW = $clog2(TAP_LEN);
  localparam logic [IW-1:0] LAST  = IW'(TAP_LEN - 1);
  localparam logic [IW-1:0] FINIT = IW'(flush_init(TAP_LEN));

  state_t                       state;
  logic [IW-1:0]                widx;
  logic [IW-1:0]                fcnt;
  logic                         shadow_full;
  logic [TAP_LEN-1:0][WIDTH-1:0] shadow;
  logic [TAP_LEN-1:0][WIDTH-1:0] bank;
  logic                         acc;
  logic                         at_last;

  fir_cke_div #(.W(DIV_W)) u_div (
    .clk (clk),
    .rst (rst),
    .div (div),
    .cke (cke)
  );

  assign cw_ready = (state == IDLE) && !shadow_full;
  assign acc      = cw_valid && cw_ready;
  assign at_last  = (widx == LAST);
  assign busy     = (state != IDLE);
  assign tap      = bank;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FLUSH;
      fcnt        <= FINIT;
      widx        <= '0;
      shadow_full <= 1'b0;
      shadow      <= '0;
      bank        <= '0;
      load_err    <= 1'b0;
      dout_valid  <= 1'b0;
      fir_clr     <= 1'b1;
    end else begin
      fir_clr <= 1'b0;
      // a mis-framed beat is dropped and the frame restarts at tap 0
      if (acc) begin
        unique case (1'b1)
          cw_last && at_last: begin
            shadow[widx] <= cw_data;
            shadow_full  <= 1'b1;
            widx         <= '0;
          end
          cw_last != at_last: begin
            load_err <= 1'b1;
            widx     <= '0;
          end
          !cw_last && !at_last: begin
            shadow[widx] <= cw_data;
            widx         <= widx + IW'(1);
          end
        endcase
      end
      unique case (state)
        IDLE: begin
          dout_valid <= 1'b1;
          if (commit && shadow_full)
            state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (cke) begin
            bank        <= shadow;
            fir_clr     <= 1'b1;
            shadow_full <= 1'b0;
            fcnt        <= FINIT;
            dout_valid  <= 1'b0;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          dout_valid <= 1'b0;
          if (cke) begin
            fcnt <= fcnt - IW'(1);
            if (fcnt <= IW'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_COEF_RDBK_EN
  always_ff @(posedge clk) begin
    if (!rst)
      rd_data <= '0;
    else if (int'(rd_addr) < TAP_LEN)
      rd_data <= bank[rd_addr];
    else
      rd_data <= '0;
  end
`endif

endmodule

// File: tb/tb_fir_coef_sched.sv
// Scoreboard bench for fir_coef_sched: swap, flush, framing, divider, reset.
module tb_fir_coef_sched;

  localparam int EV_CLR = 0;
  localparam int EV_TAP = 1;
  localparam int EV_DV  = 2;

  localparam logic [127:0] TAP_A = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] TAP_B = 128'hF0F0_0F0F_ABCD_1234_0000_FFFF_7FFF_8001;
  localparam logic [127:0] TAP_C = 128'h0080_0070_0060_0050_0040_0030_0020_0010;

  typedef struct {
    int           k;
    logic [127:0] d;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   div;
  logic         cw_valid;
  logic         cw_ready;
  logic [15:0]  cw_data;
  logic         cw_last;
  logic         commit;
  logic         busy;
  logic         cke;
  logic         fir_clr;
  logic [127:0] tap;
  logic         dout_valid;
  logic         load_err;

  int compared   = 0;
  int mismatched = 0;
  ev_t q[$];

  logic [15:0] beats_b [8] = '{16'h8001, 16'h7FFF, 16'hFFFF, 16'h0000,
                               16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0};

  fir_coef_sched dut (
    .clk        (clk),
    .rst        (rst),
    .div        (div),
    .cw_valid   (cw_valid),
    .cw_ready   (cw_ready),
    .cw_data    (cw_data),
    .cw_last    (cw_last),
    .commit     (commit),
    .busy       (busy),
    .cke        (cke),
    .fir_clr    (fir_clr),
    .tap        (tap),
    .dout_valid (dout_valid),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tout(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic void expect_ev(input int k, input logic [127:0] d);
    q.push_back('{k, d});
  endfunction

  task automatic pop_chk(input int k, input logic [127:0] d, input string nm);
    ev_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected event data %0h", nm, d);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.d !== d) begin
        mismatched++;
        $display("FAIL %s: got kind %0d data %0h want kind %0d data %0h",
                 nm, k, d, e.k, e.d);
      end
    end
  endtask

  // monitor: turns DUT output changes into events and checks them
  int           cnt_cke = 0;
  logic         clr_pend = 1'b0;
  logic         p_clr = 1'b0;
  logic         p_dv = 1'b0;
  logic         p_cke = 1'b0;
  logic [127:0] p_tap = '0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      clr_pend = 1'b0;
    end else begin
      if (clr_pend) chk("clr_width", fir_clr, 0);
      clr_pend = fir_clr && !p_clr;
      if (clr_pend) pop_chk(EV_CLR, 0, "ev_clr");
      if (tap !== p_tap) begin
        pop_chk(EV_TAP, tap, "ev_tap");
        chk("tap_after_cke", p_cke, 1);
      end
      if (dout_valid !== p_dv)
        pop_chk(EV_DV, dout_valid ? 128'(1000 + cnt_cke) : 128'd0, "ev_dv");
    end
    if (fir_clr !== 1'b0) cnt_cke = 0;
    if (cke === 1'b1) cnt_cke++;
    p_clr = fir_clr;
    p_tap = tap;
    p_dv  = dout_valid;
    p_cke = cke;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last, input int gap);
    int n;
    repeat (gap) step();
    cw_valid = 1'b1;
    cw_data  = d;
    cw_last  = last;
    n = 0;
    @(negedge clk);
    while (!cw_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cw_ready) tout("beat_accept");
    step();
    cw_valid = 1'b0;
    cw_last  = 1'b0;
  endtask

  task automatic wait_dv(input logic v, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (dout_valid !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (dout_valid !== v) tout(nm);
    step();
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic expect_swap(input logic [127:0] t);
    expect_ev(EV_CLR, 0);
    expect_ev(EV_TAP, t);
    expect_ev(EV_DV, 0);
    expect_ev(EV_DV, 1007);
  endtask

  initial begin
    int n;
    int per;
    rst = 1'b0;
    div = 8'd3;
    cw_valid = 1'b0;
    cw_data = '0;
    cw_last = 1'b0;
    commit = 1'b0;

    // reset and first flush
    expect_ev(EV_DV, 1007);
    step();
    @(negedge clk);
    chk("rst_cke", cke, 0);
    chk("rst_clr", fir_clr, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tap", tap, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", cw_ready, 0);
    chk("rst_err", load_err, 0);
    n = 0;
    while (!cke && n < 50) begin
      @(negedge clk);
      n++;
    end
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (!cke && per < 50);
    chk("cke_period", per, 4);
    step();
    wait_dv(1, "rst_flush");

    // full load 1..8 then commit
    for (int i = 0; i < 8; i++) send(16'(i + 1), i == 7, 0);
    @(negedge clk);
    chk("full_ready", cw_ready, 0);
    chk("full_busy", busy, 0);
    step();
    expect_swap(TAP_A);
    pulse_commit();
    @(negedge clk);
    chk("commit_busy", busy, 1);
    step();
    wait_dv(0, "swap_a");
    wait_dv(1, "flush_a");

    // short frame: error, commit ignored
    for (int i = 0; i < 5; i++) send(16'(i + 9), i == 4, 0);
    @(negedge clk);
    chk("short_err", load_err, 1);
    chk("short_ready", cw_ready, 1);
    step();
    pulse_commit();
    repeat (10) step();
    @(negedge clk);
    chk("short_busy", busy, 0);
    chk("short_tap", tap, TAP_A);
    step();

    // gapped load, then noise on inputs during the flush
    for (int i = 0; i < 8; i++)
      send(beats_b[i], i == 7, int'($urandom_range(0, 2)));
    expect_swap(TAP_B);
    pulse_commit();
    for (int i = 0; i < 20; i++) begin
      cw_valid = 1'($urandom_range(0, 1));
      cw_last  = 1'($urandom_range(0, 1));
      commit   = 1'($urandom_range(0, 1));
      cw_data  = 16'hDEAD;
      @(negedge clk);
      if (i == 2 || i == 19) chk("flush_busy", busy, 1);
      if (busy) chk("flush_ready", cw_ready, 0);
      step();
    end
    cw_valid = 1'b0;
    cw_last  = 1'b0;
    commit   = 1'b0;
    wait_dv(1, "flush_b");
    @(negedge clk);
    chk("tap_b", tap, TAP_B);
    chk("err_sticky", load_err, 1);
    step();

    // divider lowered below the running count
    div = 8'd200;
    n = 0;
    @(negedge clk);
    while (!cke && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cke) tout("div200");
    repeat (150) @(posedge clk);
    #1;
    div = 8'd2;
    @(negedge clk);
    chk("div_c0", cke, 0);
    @(negedge clk);
    chk("div_c1", cke, 1);
    @(negedge clk);
    chk("div_c2", cke, 0);
    @(negedge clk);
    chk("div_c3", cke, 0);
    @(negedge clk);
    chk("div_c4", cke, 1);
    step();

    // reset mid-load, then a clean reload
    for (int i = 0; i < 3; i++) send(16'((i + 1) * 16), 1'b0, 0);
    expect_ev(EV_DV, 1007);
    cw_valid = 1'b1;
    cw_data  = 16'h0040;
    rst      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_cke", cke, 0);
    chk("mid_clr", fir_clr, 1);
    chk("mid_tap", tap, 0);
    chk("mid_dv", dout_valid, 0);
    chk("mid_err", load_err, 0);
    chk("mid_busy", busy, 1);
    step();
    rst = 1'b1;
    cw_valid = 1'b0;
    @(negedge clk);
    chk("mid_ready", cw_ready, 0);
    step();
    wait_dv(1, "flush_rst");
    for (int i = 0; i < 8; i++) send(16'((i + 1) * 16), i == 7, 0);
    @(negedge clk);
    chk("reload_err", load_err, 0);
    step();
    expect_swap(TAP_C);
    pulse_commit();
    wait_dv(0, "swap_c");
    wait_dv(1, "flush_c");
    @(negedge clk);
    chk("tap_c", tap, TAP_C);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
